// File: rtl/key_event_arbiter_pkg.sv
// Shared constants for the key event arbiter: key index names and index-width helper.
package key_event_arbiter_pkg;

    localparam int unsigned NKEYS     = 4;
    localparam int unsigned KEY_IDX_W = $clog2(NKEYS);

    localparam logic [KEY_IDX_W-1:0] KEY_LAUNCH     = KEY_IDX_W'(0);
    localparam logic [KEY_IDX_W-1:0] KEY_SHIFT_UP   = KEY_IDX_W'(1);
    localparam logic [KEY_IDX_W-1:0] KEY_SHIFT_DOWN = KEY_IDX_W'(2);
    localparam logic [KEY_IDX_W-1:0] KEY_NITRO      = KEY_IDX_W'(3);

    // Index width that stays >= 1 for degenerate single-entry cases.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests, search starting after the last winner.
module rr_arbiter
    import key_event_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    // ptr_q holds the first index to search, i.e. one past the last winner.
    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   j;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        idx       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            j   = (32'(ptr_q) + off) % N;
            idx = IW'(j);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Latches per-key edge pulses, grants them round-robin into a small FIFO and counts coalesced presses.
module key_event_arbiter
    import key_event_arbiter_pkg::*;
#(
    parameter  int unsigned NKEYS      = key_event_arbiter_pkg::NKEYS,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned DROP_W     = 8,
    localparam int unsigned IW         = idx_width(NKEYS),
    localparam int unsigned AW         = idx_width(FIFO_DEPTH),
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NKEYS-1:0]  key_posedge,
    output logic              evt_valid,
    output logic [IW-1:0]     evt_key,
    input  logic              evt_ready,
    output logic [NKEYS-1:0]  pending,
    output logic [CW-1:0]     fifo_count,
    output logic [DROP_W-1:0] drop_count,
    input  logic              clear_drops
);

    logic [NKEYS-1:0]  pending_q, pending_d;
    logic [NKEYS-1:0]  grant;
    logic [IW-1:0]     grant_idx;
    logic [NKEYS-1:0]  coalesce;
    logic [IW:0]       drop_inc;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [IW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full, push, pop;

    // Fullness uses the registered count only, so a same-cycle pop never frees a slot.
    assign full = (count_q == CW'(FIFO_DEPTH));
    assign push = |grant;
    assign pop  = evt_valid && evt_ready;

    rr_arbiter #(
        .N (NKEYS)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (pending_q),
        .en        (!full),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A pulse on a key being granted this cycle is a fresh event, not a drop.
    always_comb begin
        coalesce  = key_posedge & pending_q & ~grant;
        pending_d = (pending_q & ~grant) | key_posedge;
        drop_inc  = '0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            drop_inc = drop_inc + (IW + 1)'(coalesce[i]);
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(drop_inc);
        if (clear_drops) begin
            drop_d = '0;
        end else if (drop_sum[DROP_W]) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            drop_q    <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign evt_valid  = (count_q != '0);
    assign evt_key    = mem_q[rd_ptr_q];
    assign pending    = pending_q;
    assign fifo_count = count_q;
    assign drop_count = drop_q;

endmodule
